// File: rtl/serial_subtractor.sv
// Slice-serial subtractor: diff = a - b - borrow_in, SLICE bits per cycle, LSB slice first.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    generate
        if ((WIDTH % SLICE) != 0 || WIDTH < 2 || SLICE < 1) begin : g_bad_params
            $error("serial_subtractor: SLICE must divide WIDTH and WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic [SLICE:0]   slice_res;
    logic [WIDTH-1:0] diff_shift;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    // Operands shift right each RUN cycle, so the active slice is always in the low bits.
    assign slice_res = {1'b0, a_q[SLICE-1:0]} - {1'b0, b_q[SLICE-1:0]}
                     - {{SLICE{1'b0}}, borrow_q};

    generate
        if (SLICE == WIDTH) begin : g_one_slice
            assign diff_shift = slice_res[SLICE-1:0];
        end else begin : g_multi_slice
            assign diff_shift = {slice_res[SLICE-1:0], diff_q[WIDTH-1:SLICE]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        diff_d    = diff_q;
        borrow_d  = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf_d     = ovf_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = borrow_in;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> SLICE;
                b_d      = b_q >> SLICE;
                diff_d   = diff_shift;
                borrow_d = slice_res[SLICE];
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    // Borrow into the MSB is a^b^diff at that bit; overflow when it differs from borrow out.
                    ovf_d = a_q[SLICE-1] ^ b_q[SLICE-1] ^ slice_res[SLICE-1] ^ slice_res[SLICE];
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign diff       = diff_q;
    assign borrow_out = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign overflow   = ovf_q;
`endif

endmodule
